weight_prefetch_buffer: RTL and testbench

WEIGHT_PREFETCH_BUFFER -- requirements
Module: weight_prefetch_buffer

---
 rtl/weight_prefetch_buffer.sv | 141 ++++++++++++++
 tb/tb_weight_prefetch_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// weight_prefetch_buffer
//
// Double-buffered weight tile store that sits between the weight SRAM and a
// systolic array. While the array computes on the active tile, the next tile
// is streamed column by column into a shadow bank. When the shadow bank is
// complete and the array asks for the next tile, the shadow bank is copied to
// the active bank in a single cycle.
//
// Ports
//   clk               clock, all logic on the rising edge
//   rstn              synchronous active-low reset
//   w_prefetch_in     tile-start pulse; discards a partially filled shadow bank
//   w_read_en_in      SRAM read issued this cycle
//   w_rdata_in        SRAM read data, valid one cycle after w_read_en_in
//   load_req_in       array requests the next tile
//   w_active_out      active tile, column c at [c*MAC_ROW*W_BITWIDTH +: ...]
//   w_valid_out       w_active_out holds a complete tile
//   swap_done_out     one-cycle pulse after the shadow tile becomes active
//   shadow_full_out   shadow bank holds a complete tile awaiting swap
//   overflow_err_out  sticky: read data arrived while the shadow bank was full
//   state_dbg         current FSM state (IDLE=0, FILL=1, FULL=2)
//
// Handshake: the tile transfer is a valid/ready pair where shadow_full_out is
// the valid and load_req_in is the ready. A swap happens on exactly the
// clock edge where both are high; load_req_in with shadow_full_out low has no
// effect, and shadow_full_out stays high (tile held) until load_req_in is seen.
// -----------------------------------------------------------------------------
module weight_prefetch_buffer #(
  parameter int MAC_ROW    = 16,
  parameter int MAC_COL    = 16,
  parameter int W_BITWIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  w_prefetch_in,
  input  logic                                  w_read_en_in,
  input  logic [MAC_ROW*W_BITWIDTH-1:0]         w_rdata_in,
  input  logic                                  load_req_in,
  output logic [MAC_COL*MAC_ROW*W_BITWIDTH-1:0] w_active_out,
  output logic                                  w_valid_out,
  output logic                                  swap_done_out,
  output logic                                  shadow_full_out,
  output logic                                  overflow_err_out,
  output logic [1:0]                            state_dbg
);

  localparam int VW    = MAC_ROW * W_BITWIDTH;
  localparam int CNT_W = $clog2(MAC_COL + 1);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(MAC_COL - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic [CNT_W-1:0]           col_cnt;
  logic [CNT_W-1:0]           cnt_nxt;
  logic [CNT_W-1:0]           base;
  logic [CNT_W-1:0]           wr_idx;
  logic                       wr_en;
  logic                       rd_valid;
  logic                       swap;
  logic                       ovf_set;
  logic [MAC_COL-1:0][VW-1:0] shadow;

  // Next-state decode. Priority: swap, then overflow in FULL, then
  // fill (with a prefetch pulse restarting the fill at column 0 before any
  // same-cycle capture lands).
  always_comb begin
    swap      = (state == ST_FULL) && load_req_in;
    state_nxt = state;
    cnt_nxt   = col_cnt;
    base      = '0;
    wr_idx    = '0;
    wr_en     = 1'b0;
    ovf_set   = 1'b0;
    if (swap) begin
      if (rd_valid) begin
        // The shadow bank is freed by this swap, so the arriving column
        // starts the next tile instead of overflowing.
        wr_en     = 1'b1;
        wr_idx    = '0;
        cnt_nxt   = CNT_W'(1);
        state_nxt = (MAC_COL == 1) ? ST_FULL : ST_FILL;
      end else begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    end else if (state == ST_FULL) begin
      ovf_set = rd_valid;
    end else begin
      base = w_prefetch_in ? '0 : col_cnt;
      if (rd_valid) begin
        wr_en     = 1'b1;
        wr_idx    = base;
        cnt_nxt   = base + CNT_W'(1);
        state_nxt = (base == LAST_COL) ? ST_FULL : ST_FILL;
      end else if (w_prefetch_in) begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      col_cnt          <= '0;
      rd_valid         <= 1'b0;
      w_valid_out      <= 1'b0;
      swap_done_out    <= 1'b0;
      overflow_err_out <= 1'b0;
      w_active_out     <= '0;
      shadow           <= '0;
    end else begin
      rd_valid      <= w_read_en_in;
      state         <= state_nxt;
      col_cnt       <= cnt_nxt;
      swap_done_out <= swap;
      if (swap) begin
        // Reads the shadow contents from before any same-cycle write.
        w_active_out <= shadow;
        w_valid_out  <= 1'b1;
      end
      if (ovf_set) begin
        overflow_err_out <= 1'b1;
      end
      for (int c = 0; c < MAC_COL; c++) begin
        if (wr_en && (wr_idx == CNT_W'(c))) begin
          shadow[c] <= w_rdata_in;
        end
      end
    end
  end

  assign shadow_full_out = (state == ST_FULL);
  assign state_dbg       = state;

endmodule

// File: tb/tb_weight_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_weight_prefetch_buffer
//
// Cycle table for a 4x4 tile of 8-bit weights. Each record gives the inputs
// for one clock and the outputs expected right after that clock. A read
// issued in record i has its data presented by the driver in record i+1.
// Records expecting a swap push their tile into exp_q; a monitor pops and
// compares whenever swap_done_out is seen.
// -----------------------------------------------------------------------------
module tb_weight_prefetch_buffer;

  localparam int MAC_ROW = 4;
  localparam int MAC_COL = 4;
  localparam int W_BITS  = 8;
  localparam int VW      = MAC_ROW * W_BITS;
  localparam int TW      = MAC_COL * VW;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_F = 2'd1;
  localparam logic [1:0] S_U = 2'd2;

  localparam logic [TW-1:0] Z  = '0;
  localparam logic [TW-1:0] T1 = 128'h04040404_03030303_02020202_01010101;
  localparam logic [TW-1:0] T2 = 128'h08080808_07070707_06060606_05050505;
  localparam logic [TW-1:0] T3 = 128'h24242424_23232323_22222222_21212121;
  localparam logic [TW-1:0] T4 = 128'h000000DD_000000CC_000000BB_000000AA;
  localparam logic [TW-1:0] T5 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [TW-1:0] T6 = 128'h7B7B7B7B_7A7A7A7A_79797979_78787878;
  localparam logic [TW-1:0] T7 = 128'h34343434_33333333_32323232_31313131;

  // clock / reset
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          w_prefetch_in = 1'b0;
  logic          w_read_en_in = 1'b0;
  logic [VW-1:0] w_rdata_in = '0;
  logic          load_req_in = 1'b0;
  logic [TW-1:0] w_active_out;
  logic          w_valid_out;
  logic          swap_done_out;
  logic          shadow_full_out;
  logic          overflow_err_out;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  weight_prefetch_buffer #(
    .MAC_ROW   (MAC_ROW),
    .MAC_COL   (MAC_COL),
    .W_BITWIDTH(W_BITS)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .w_prefetch_in   (w_prefetch_in),
    .w_read_en_in    (w_read_en_in),
    .w_rdata_in      (w_rdata_in),
    .load_req_in     (load_req_in),
    .w_active_out    (w_active_out),
    .w_valid_out     (w_valid_out),
    .swap_done_out   (swap_done_out),
    .shadow_full_out (shadow_full_out),
    .overflow_err_out(overflow_err_out),
    .state_dbg       (state_dbg)
  );

  typedef struct {
    logic          rstn;
    logic          pf;
    logic          rd;
    logic [VW-1:0] data;
    logic          ld;
    logic [1:0]    st;
    logic          full;
    logic          ovf;
    logic          swap;
    logic          valid;
    logic [TW-1:0] act;
  } vec_t;

  vec_t          tbl[$];
  logic [TW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_cmp = 0;
  int            miscompares = 0;
  int            cur = 0;

  task automatic add(input logic r, input logic pf, input logic rd,
                     input logic [VW-1:0] d, input logic ld,
                     input logic [1:0] st, input logic full, input logic ovf,
                     input logic swap, input logic valid,
                     input logic [TW-1:0] act);
    vec_t v;
    v.rstn = r; v.pf = pf; v.rd = rd; v.data = d; v.ld = ld;
    v.st = st; v.full = full; v.ovf = ovf; v.swap = swap; v.valid = valid;
    v.act = act;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [TW-1:0] got,
                     input logic [TW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, cur, got, want);
    end
  endtask

  // scoreboard monitor: every swap pulse must match the oldest queued tile
  always @(posedge clk) begin
    #1;
    if (rstn && swap_done_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        miscompares++;
        $display("FAIL sb_unexpected_swap vec %0d: got swap tile %0h want none",
                 cur, w_active_out);
      end else begin
        chk("sb_tile", w_active_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [VW-1:0] pend;
    pend = '0;

    //  rstn pf rd data          ld  st   full ovf swap valid act
    // basic fill and swap
    add(0, 0, 0, 32'h0,        0, S_I, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h01010101, 0, S_I, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h02020202, 0, S_F, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h03030303, 0, S_F, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h04040404, 0, S_F, 0, 0, 0, 0, Z);
    add(1, 0, 0, 32'h0,        0, S_U, 1, 0, 0, 0, Z);
    add(1, 0, 0, 32'h0,        1, S_I, 0, 0, 1, 1, T1);
    add(1, 0, 0, 32'h0,        0, S_I, 0, 0, 0, 1, T1);
    // overflow while full, tile preserved
    add(1, 0, 1, 32'h05050505, 0, S_I, 0, 0, 0, 1, T1);
    add(1, 0, 1, 32'h06060606, 0, S_F, 0, 0, 0, 1, T1);
    add(1, 0, 1, 32'h07070707, 0, S_F, 0, 0, 0, 1, T1);
    add(1, 0, 1, 32'h08080808, 0, S_F, 0, 0, 0, 1, T1);
    add(1, 0, 1, 32'h99999999, 0, S_U, 1, 0, 0, 1, T1);
    add(1, 0, 0, 32'h0,        0, S_U, 1, 1, 0, 1, T1);
    add(1, 0, 0, 32'h0,        1, S_I, 0, 1, 1, 1, T2);
    add(1, 0, 0, 32'h0,        0, S_I, 0, 1, 0, 1, T2);
    // reset, then swap coinciding with a capture
    add(0, 0, 0, 32'h0,        0, S_I, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h21212121, 0, S_I, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h22222222, 0, S_F, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h23232323, 0, S_F, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h24242424, 0, S_F, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h000000AA, 0, S_U, 1, 0, 0, 0, Z);
    add(1, 0, 0, 32'h0,        1, S_F, 0, 0, 1, 1, T3);
    add(1, 0, 1, 32'h000000BB, 0, S_F, 0, 0, 0, 1, T3);
    add(1, 0, 1, 32'h000000CC, 0, S_F, 0, 0, 0, 1, T3);
    add(1, 0, 1, 32'h000000DD, 0, S_F, 0, 0, 0, 1, T3);
    add(1, 0, 0, 32'h0,        0, S_U, 1, 0, 0, 1, T3);
    add(1, 0, 0, 32'h0,        1, S_I, 0, 0, 1, 1, T4);
    // prefetch discards a partial fill
    add(1, 0, 1, 32'h5A5A5A5A, 0, S_I, 0, 0, 0, 1, T4);
    add(1, 0, 1, 32'h6B6B6B6B, 0, S_F, 0, 0, 0, 1, T4);
    add(1, 0, 0, 32'h0,        0, S_F, 0, 0, 0, 1, T4);
    add(1, 1, 0, 32'h0,        0, S_I, 0, 0, 0, 1, T4);
    add(1, 0, 1, 32'h11111111, 0, S_I, 0, 0, 0, 1, T4);
    add(1, 0, 1, 32'h22222222, 0, S_F, 0, 0, 0, 1, T4);
    add(1, 0, 1, 32'h33333333, 0, S_F, 0, 0, 0, 1, T4);
    add(1, 0, 1, 32'h44444444, 0, S_F, 0, 0, 0, 1, T4);
    add(1, 0, 0, 32'h0,        0, S_U, 1, 0, 0, 1, T4);
    add(1, 0, 0, 32'h0,        1, S_I, 0, 0, 1, 1, T5);
    // prefetch with same-cycle capture; prefetch while full is ignored
    add(1, 0, 1, 32'h77777777, 0, S_I, 0, 0, 0, 1, T5);
    add(1, 0, 1, 32'h78787878, 0, S_F, 0, 0, 0, 1, T5);
    add(1, 1, 1, 32'h79797979, 0, S_F, 0, 0, 0, 1, T5);
    add(1, 0, 1, 32'h7A7A7A7A, 0, S_F, 0, 0, 0, 1, T5);
    add(1, 0, 1, 32'h7B7B7B7B, 0, S_F, 0, 0, 0, 1, T5);
    add(1, 0, 0, 32'h0,        0, S_U, 1, 0, 0, 1, T5);
    add(1, 1, 0, 32'h0,        0, S_U, 1, 0, 0, 1, T5);
    add(1, 0, 0, 32'h0,        1, S_I, 0, 0, 1, 1, T6);
    // load_req held with nothing to swap
    for (int k = 0; k < 10; k++) add(1, 0, 0, 32'h0, 1, S_I, 0, 0, 0, 1, T6);
    // reset mid-fill, then a clean fill from column 0
    add(1, 0, 1, 32'hE1E1E1E1, 0, S_I, 0, 0, 0, 1, T6);
    add(1, 0, 1, 32'hE2E2E2E2, 0, S_F, 0, 0, 0, 1, T6);
    add(1, 0, 0, 32'h0,        0, S_F, 0, 0, 0, 1, T6);
    add(0, 0, 0, 32'h0,        0, S_I, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h31313131, 0, S_I, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h32323232, 0, S_F, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h33333333, 0, S_F, 0, 0, 0, 0, Z);
    add(1, 0, 1, 32'h34343434, 0, S_F, 0, 0, 0, 0, Z);
    add(1, 0, 0, 32'h0,        0, S_U, 1, 0, 0, 0, Z);
    add(1, 0, 0, 32'h0,        1, S_I, 0, 0, 1, 1, T7);
    add(1, 0, 0, 32'h0,        0, S_I, 0, 0, 0, 1, T7);

    // driver + per-cycle checks
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      cur           = i;
      rstn          = tbl[i].rstn;
      w_prefetch_in = tbl[i].pf;
      w_read_en_in  = tbl[i].rd;
      load_req_in   = tbl[i].ld;
      w_rdata_in    = pend;
      pend          = tbl[i].data;
      if (tbl[i].swap) exp_q.push_back(tbl[i].act);
      @(posedge clk);
      #1;
      n_vec++;
      chk("state",    TW'(state_dbg),        TW'(tbl[i].st));
      chk("full",     TW'(shadow_full_out),  TW'(tbl[i].full));
      chk("overflow", TW'(overflow_err_out), TW'(tbl[i].ovf));
      chk("swap",     TW'(swap_done_out),    TW'(tbl[i].swap));
      chk("valid",    TW'(w_valid_out),      TW'(tbl[i].valid));
      chk("active",   w_active_out,          tbl[i].act);
    end

    @(negedge clk);
    w_read_en_in  = 1'b0;
    load_req_in   = 1'b0;
    w_prefetch_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_leftover", TW'(exp_q.size()), TW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
